// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush/hold control
// and saturating bubble/hold performance counters.
module id_ex_stage #(
    parameter int unsigned W     = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ID_valid,
    input  logic [5:0]       ID_opcode,
    input  logic [5:0]       ID_funct,
    input  logic [4:0]       ID_RS,
    input  logic [4:0]       ID_RT,
    input  logic [4:0]       ID_RD,
    input  logic [W-1:0]     ID_rdata1,
    input  logic [W-1:0]     ID_rdata2,
    input  logic [W-1:0]     ID_imm,
    input  logic [W-1:0]     ID_PC4,
    input  logic             flush,
    input  logic             mem_stall,
    output logic [5:0]       opcode_EX,
    output logic [5:0]       funct_EX,
    output logic [4:0]       EX_RS,
    output logic [4:0]       EX_RT,
    output logic [4:0]       EX_WR,
    output logic [W-1:0]     EX_rdata1,
    output logic [W-1:0]     EX_rdata2,
    output logic [W-1:0]     EX_imm,
    output logic [W-1:0]     EX_PC4,
    output logic             EX_valid,
    output logic             lu_stall,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] hold_cnt
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    logic [5:0]       r_opcode;
    logic [5:0]       r_funct;
    logic [4:0]       r_rs;
    logic [4:0]       r_rt;
    logic [4:0]       r_wr;
    logic [W-1:0]     r_rdata1;
    logic [W-1:0]     r_rdata2;
    logic [W-1:0]     r_imm;
    logic [W-1:0]     r_pc4;
    logic             r_valid;
    logic [CNT_W-1:0] r_bubble_cnt;
    logic [CNT_W-1:0] r_hold_cnt;

    logic             w_reads_rt;
    logic             w_lu_hz;
    logic             w_load_bubble;
    logic [4:0]       w_wr;

    // Hazard detection against the load currently sitting in EX.
    always_comb begin
        w_reads_rt    = (ID_opcode == OP_RTYPE) || (ID_opcode == OP_BEQ) ||
                        (ID_opcode == OP_BNE)   || (ID_opcode == OP_SW);
        w_lu_hz       = r_valid && (r_opcode == OP_LW) && (r_rt != 5'd0) && ID_valid &&
                        ((ID_RS == r_rt) || (w_reads_rt && (ID_RT == r_rt)));
        w_load_bubble = flush || w_lu_hz || !ID_valid;
        w_wr          = (ID_opcode == OP_RTYPE) ? ID_RD : ID_RT;
    end

    // Pipeline register: hold on mem_stall, bubble on flush/hazard/invalid, else capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_opcode <= '0;
            r_funct  <= '0;
            r_rs     <= '0;
            r_rt     <= '0;
            r_wr     <= '0;
            r_rdata1 <= '0;
            r_rdata2 <= '0;
            r_imm    <= '0;
            r_pc4    <= '0;
            r_valid  <= 1'b0;
        end else if (!mem_stall) begin
            if (w_load_bubble) begin
                r_opcode <= '0;
                r_funct  <= '0;
                r_rs     <= '0;
                r_rt     <= '0;
                r_wr     <= '0;
                r_rdata1 <= '0;
                r_rdata2 <= '0;
                r_imm    <= '0;
                r_pc4    <= '0;
                r_valid  <= 1'b0;
            end else begin
                r_opcode <= ID_opcode;
                r_funct  <= ID_funct;
                r_rs     <= ID_RS;
                r_rt     <= ID_RT;
                r_wr     <= w_wr;
                r_rdata1 <= ID_rdata1;
                r_rdata2 <= ID_rdata2;
                r_imm    <= ID_imm;
                r_pc4    <= ID_PC4;
                r_valid  <= 1'b1;
            end
        end
    end

    // Saturating performance counters: holds and inserted bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bubble_cnt <= '0;
            r_hold_cnt   <= '0;
        end else if (mem_stall) begin
            if (r_hold_cnt != '1) begin
                r_hold_cnt <= r_hold_cnt + CNT_W'(1);
            end
        end else if (flush || w_lu_hz) begin
            if (r_bubble_cnt != '1) begin
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
            end
        end
    end

    assign opcode_EX  = r_opcode;
    assign funct_EX   = r_funct;
    assign EX_RS      = r_rs;
    assign EX_RT      = r_rt;
    assign EX_WR      = r_wr;
    assign EX_rdata1  = r_rdata1;
    assign EX_rdata2  = r_rdata2;
    assign EX_imm     = r_imm;
    assign EX_PC4     = r_pc4;
    assign EX_valid   = r_valid;
    assign lu_stall   = w_lu_hz && !flush && !mem_stall;
    assign bubble_cnt = r_bubble_cnt;
    assign hold_cnt   = r_hold_cnt;

endmodule
